// File: rtl/pipe_alu_pkg.sv
// Shared constants for the two-stage pipelined ALU:
// operation encoding and flag bit positions.
package pipe_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } op_e;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath between the operand and result stages.
// Ports: a, b, op in; result, flags {V,N,Z,C} out.
module alu_core
   import pipe_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shl_t;
   logic [WIDTH:0]   shr_t;
   logic [SHW-1:0]   sh;
   logic             big;
   logic             at_w;
   logic [WIDTH-1:0] res;
   logic             c;
   logic             v;

   assign sh   = b[SHW-1:0];
   assign big  = (b >= W_VAL);
   assign at_w = (b == W_VAL);

   // One extra bit catches the last bit shifted out; a zero
   // shift leaves that bit clear, so carry is 0 for free.
   assign shl_t = {1'b0, a} << sh;
   assign shr_t = {a, 1'b0} >> sh;

   always_comb begin
      sum = '0;
      res = '0;
      c   = 1'b0;
      v   = 1'b0;
      unique case (op)
         OP_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            res = sum[WIDTH-1:0];
            c   = sum[WIDTH];
            v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                  (res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            res = sum[WIDTH-1:0];
            c   = sum[WIDTH];
            v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                  (res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_NOT: res = ~a;
         OP_SHL: begin
            if (big) begin
               res = '0;
               c   = at_w ? a[WIDTH-1] : 1'b0;
            end else begin
               res = shl_t[WIDTH-1:0];
               c   = shl_t[WIDTH];
            end
         end
         OP_SHR: begin
            if (big) begin
               res = '0;
               c   = at_w ? a[0] : 1'b0;
            end else begin
               res = shr_t[WIDTH:1];
               c   = shr_t[0];
            end
         end
      endcase
   end

   assign result        = res;
   assign flags[FLAG_C] = c;
   assign flags[FLAG_Z] = (res == '0);
   assign flags[FLAG_N] = res[WIDTH-1];
   assign flags[FLAG_V] = v;

endmodule

// File: rtl/pipe_alu.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides.
// Ports: clk, rst, in_valid/in_ready/a/b/op, out_valid/out_ready/result/flags.
module pipe_alu
   import pipe_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   logic             en;
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [2:0]       s1_op;
   logic [WIDTH-1:0] alu_res;
   logic [3:0]       alu_flags;

   // Single global enable: the whole pipe moves or freezes together.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
      end else if (en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a  <= a;
            s1_b  <= b;
            s1_op <= op;
         end
      end
   end

   alu_core #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_core (
      .a      (s1_a),
      .b      (s1_b),
      .op     (s1_op),
      .result (alu_res),
      .flags  (alu_flags)
   );

   // Result/flags only load with a real op so they hold the
   // last delivered value across bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else if (en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result <= alu_res;
            flags  <= alu_flags;
         end
      end
   end

endmodule

// File: tb/tb_pipe_alu.sv
// Self-checking bench for pipe_alu: directed vectors, stall,
// reset flush, and random traffic on WIDTH=8 and WIDTH=32.
module tb_pipe_alu;

   logic        clk = 1'b0;
   logic        rst;

   logic        iv8, ir8, ov8, or8;
   logic [7:0]  a8, b8, res8;
   logic [2:0]  op8;
   logic [3:0]  fl8;

   logic        iv32, ir32, ov32, or32;
   logic [31:0] a32, b32, res32;
   logic [2:0]  op32;
   logic [3:0]  fl32;

   int total = 0;
   int bad   = 0;

   logic [67:0] q8[$];
   logic [67:0] q32[$];

   always #5 clk = ~clk;

   pipe_alu #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv8),
      .in_ready  (ir8),
      .a         (a8),
      .b         (b8),
      .op        (op8),
      .out_valid (ov8),
      .out_ready (or8),
      .result    (res8),
      .flags     (fl8)
   );

   pipe_alu #(.WIDTH(32)) dut32 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv32),
      .in_ready  (ir32),
      .a         (a32),
      .b         (b32),
      .op        (op32),
      .out_valid (ov32),
      .out_ready (or32),
      .result    (res32),
      .flags     (fl32)
   );

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain unsigned arithmetic on a w-bit word.
   function automatic void model(input int w,
                                 input logic [63:0] ai,
                                 input logic [63:0] bi,
                                 input logic [2:0] o,
                                 output logic [63:0] r,
                                 output logic [3:0] f);
      logic [63:0] m, x, y;
      logic [64:0] s;
      logic c, v, sa, sb;
      int k;
      m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      x = ai & m;
      y = bi & m;
      sa = x[w-1];
      sb = y[w-1];
      c = 1'b0;
      v = 1'b0;
      r = '0;
      case (o)
         3'd0: begin
            s = {1'b0, x} + {1'b0, y};
            r = s[63:0] & m;
            c = s[w];
            v = (sa == sb) && (r[w-1] != sa);
         end
         3'd1: begin
            r = (x - y) & m;
            c = (x >= y);
            v = (sa != sb) && (r[w-1] != sa);
         end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         3'd5: r = ~x & m;
         3'd6: begin
            if (y == 0) r = x;
            else if (y < 64'(w)) begin
               k = int'(y);
               r = (x << k) & m;
               c = x[w-k];
            end else begin
               r = '0;
               c = (y == 64'(w)) ? x[w-1] : 1'b0;
            end
         end
         default: begin
            if (y == 0) r = x;
            else if (y < 64'(w)) begin
               k = int'(y);
               r = x >> k;
               c = x[k-1];
            end else begin
               r = '0;
               c = (y == 64'(w)) ? x[0] : 1'b0;
            end
         end
      endcase
      f = {v, r[w-1], (r == 0), c};
   endfunction

   task automatic run_one(input string tag,
                          input logic [7:0] ai,
                          input logic [7:0] bi,
                          input logic [2:0] o,
                          input logic [7:0] er,
                          input logic [3:0] ef);
      or8 = 1'b1;
      iv8 = 1'b1;
      a8  = ai;
      b8  = bi;
      op8 = o;
      tick();
      iv8 = 1'b0;
      chk({tag, "_lat1"}, 64'(ov8), 64'd0);
      tick();
      chk({tag, "_valid"}, 64'(ov8), 64'd1);
      chk({tag, "_res"}, 64'(res8), 64'(er));
      chk({tag, "_flags"}, 64'(fl8), 64'(ef));
      tick();
   endtask

   logic [7:0]  va[5] = '{8'h10, 8'h05, 8'hF0, 8'h81, 8'h0C};
   logic [7:0]  vb[5] = '{8'h20, 8'h09, 8'h3C, 8'h03, 8'h30};
   logic [2:0]  vo[5] = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd3};

   initial begin
      logic [63:0] r;
      logic [3:0]  f;
      logic [67:0] e;
      logic        stall_prev;
      logic [7:0]  held;
      int          issued;
      int          got;

      rst = 1'b1;
      iv8 = 0; or8 = 0; a8 = 0; b8 = 0; op8 = 0;
      iv32 = 0; or32 = 1; a32 = 0; b32 = 0; op32 = 0;
      tick();
      tick();
      chk("rst_ov", 64'(ov8), 64'd0);
      chk("rst_res", 64'(res8), 64'd0);
      chk("rst_flags", 64'(fl8), 64'd0);
      chk("rst_ready", 64'(ir8), 64'd1);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", 64'(ir8), 64'd1);

      run_one("add_ff_01", 8'hFF, 8'h01, 3'd0, 8'h00, 4'b0011);
      run_one("sub_80_01", 8'h80, 8'h01, 3'd1, 8'h7F, 4'b1001);
      run_one("sub_01_02", 8'h01, 8'h02, 3'd1, 8'hFF, 4'b0100);
      run_one("shl_81_1",  8'h81, 8'h01, 3'd6, 8'h02, 4'b0001);
      run_one("shr_81_9",  8'h81, 8'h09, 3'd7, 8'h00, 4'b0010);
      run_one("shr_81_8",  8'h81, 8'h08, 3'd7, 8'h00, 4'b0011);

      // Five back-to-back ops with the consumer stalled for 4 cycles.
      issued = 0;
      got = 0;
      stall_prev = 1'b0;
      held = '0;
      for (int k = 0; k < 40 && got < 5; k++) begin
         or8 = !(k >= 3 && k < 7);
         iv8 = (issued < 5);
         if (issued < 5) begin
            a8  = va[issued];
            b8  = vb[issued];
            op8 = vo[issued];
         end
         #1;
         if (ov8 && !or8) chk("stall_ready", 64'(ir8), 64'd0);
         if (stall_prev) chk("stall_hold", 64'(res8), 64'(held));
         stall_prev = ov8 && !or8;
         held = res8;
         if (ov8 && or8) begin
            model(8, 64'(va[got]), 64'(vb[got]), vo[got], r, f);
            chk("stall_res", 64'(res8), r);
            chk("stall_flags", 64'(fl8), 64'(f));
            got++;
         end
         if (iv8 && ir8) issued++;
         tick();
      end
      chk("stall_count", 64'(got), 64'd5);
      iv8 = 1'b0;
      or8 = 1'b1;
      tick();
      tick();
      chk("stall_no_dup", 64'(ov8), 64'd0);

      // Reset with two ops in flight must flush both.
      iv8 = 1'b1; a8 = 8'h03; b8 = 8'h04; op8 = 3'd0;
      tick();
      a8 = 8'h05; b8 = 8'h06;
      tick();
      iv8 = 1'b0;
      rst = 1'b1;
      tick();
      chk("flush_ov", 64'(ov8), 64'd0);
      chk("flush_res", 64'(res8), 64'd0);
      chk("flush_flags", 64'(fl8), 64'd0);
      chk("flush_ready", 64'(ir8), 64'd1);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("flush_stale", 64'(ov8), 64'd0);
      end

      // Random traffic on both widths against the reference.
      for (int k = 0; k < 12000; k++) begin
         iv8  = ($urandom_range(0, 3) != 0);
         a8   = 8'($urandom);
         b8   = ($urandom_range(0, 2) == 0) ?
                8'($urandom_range(0, 12)) : 8'($urandom);
         op8  = 3'($urandom_range(0, 7));
         or8  = ($urandom_range(0, 3) != 0);
         iv32 = ($urandom_range(0, 3) != 0);
         a32  = $urandom;
         b32  = ($urandom_range(0, 2) == 0) ?
                32'($urandom_range(0, 40)) : $urandom;
         op32 = 3'($urandom_range(0, 7));
         or32 = ($urandom_range(0, 3) != 0);
         #1;
         if (iv8 && ir8) begin
            model(8, 64'(a8), 64'(b8), op8, r, f);
            q8.push_back({f, r});
         end
         if (iv32 && ir32) begin
            model(32, 64'(a32), 64'(b32), op32, r, f);
            q32.push_back({f, r});
         end
         if (ov8 && or8) begin
            if (q8.size() == 0) chk("rnd8_extra", 64'd1, 64'd0);
            else begin
               e = q8.pop_front();
               chk("rnd8_res", 64'(res8), e[63:0]);
               chk("rnd8_flags", 64'(fl8), 64'(e[67:64]));
            end
         end
         if (ov32 && or32) begin
            if (q32.size() == 0) chk("rnd32_extra", 64'd1, 64'd0);
            else begin
               e = q32.pop_front();
               chk("rnd32_res", 64'(res32), e[63:0]);
               chk("rnd32_flags", 64'(fl32), 64'(e[67:64]));
            end
         end
         tick();
      end

      iv8 = 1'b0; or8 = 1'b1;
      iv32 = 1'b0; or32 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (ov8 && q8.size() > 0) begin
            e = q8.pop_front();
            chk("drain8_res", 64'(res8), e[63:0]);
         end
         if (ov32 && q32.size() > 0) begin
            e = q32.pop_front();
            chk("drain32_res", 64'(res32), e[63:0]);
         end
         tick();
      end
      chk("drain8_empty", 64'(q8.size()), 64'd0);
      chk("drain32_empty", 64'(q32.size()), 64'd0);
      chk("drain8_idle", 64'(ov8), 64'd0);
      chk("drain32_idle", 64'(ov32), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
